// File: rtl/test_add_suite_pkg.sv
// Shared types and golden vector tables for the add/vadd/mac
// self-checking harness.
package test_add_suite_pkg;

  localparam int LW = 8;
  localparam int LN = 4;
  localparam int NT = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN_ADD,
    RUN_VADD,
    RUN_MAC,
    DONE,
    FAIL
  } state_t;

  typedef logic [LW-1:0] lane_t;

  localparam lane_t ADD_A [NT] = '{
    8'd0, 8'd1, 8'd127, 8'd255,
    8'd200, 8'd255, 8'd15, 8'd85
  };
  localparam lane_t ADD_B [NT] = '{
    8'd0, 8'd2, 8'd1, 8'd1,
    8'd100, 8'd255, 8'd240, 8'd170
  };
  localparam lane_t ADD_Y [NT] = '{
    8'd0, 8'd3, 8'd128, 8'd0,
    8'd44, 8'd254, 8'd255, 8'd255
  };

  localparam lane_t MAC_A [NT] = '{
    8'd0, 8'd2, 8'd16, 8'd255,
    8'd10, 8'd128, 8'd7, 8'd3
  };
  localparam lane_t MAC_B [NT] = '{
    8'd0, 8'd3, 8'd16, 8'd255,
    8'd10, 8'd2, 8'd9, 8'd5
  };
  localparam lane_t MAC_C [NT] = '{
    8'd0, 8'd4, 8'd1, 8'd0,
    8'd56, 8'd0, 8'd200, 8'd255
  };
  localparam lane_t MAC_Y [NT] = '{
    8'd0, 8'd10, 8'd1, 8'd1,
    8'd156, 8'd0, 8'd7, 8'd14
  };

endpackage

// File: rtl/test_add_suite_if.sv
// Status outputs of the self-checking harness.
// master drives fail/finish, slave observes them.
interface test_add_suite_if;
  logic fail;
  logic finish;

  modport master (output fail, finish);
  modport slave  (input  fail, finish);
endinterface

// File: rtl/test_add_suite_add_lane.sv
// 8-bit registered adder, wraps mod 256.
// Used once for ADD and once per VADD lane.
module add_lane
  import test_add_suite_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  lane_t a,
  input  lane_t b,
  output lane_t y
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) y <= '0;
    else        y <= a + b;
  end

endmodule

// File: rtl/test_add_suite.sv
// Self-checking harness: walks ADD, VADD and MAC vector tables
// through registered datapaths and flags the first mismatch.
module test_add_suite
  import test_add_suite_pkg::*;
#(
  parameter int NUM_VEC      = 8,
  parameter bit INJECT_FAULT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  test_add_suite_if.master bus
);

  localparam logic [3:0] LAST = 4'(NUM_VEC);

  state_t      state;
  state_t      ph_q;
  logic [3:0]  idx;
  logic [2:0]  sel;
  logic [2:0]  idx_q;
  logic        run;
  logic        issue;
  logic        vld_q;
  logic        flip;
  logic        mismatch;
  logic        fail_q;
  logic        finish_q;

  lane_t               add_y;
  lane_t               mac_y;
  logic [LN*LW-1:0]    vadd_y;
  logic [LN*LW-1:0]    vexp;
  logic [LN*LW-1:0]    exp_d;
  logic [LN*LW-1:0]    exp_q;
  logic [LN*LW-1:0]    got;

  assign sel   = idx[2:0];
  assign run   = (state == RUN_ADD) || (state == RUN_VADD) ||
                 (state == RUN_MAC);
  assign issue = run && (idx < LAST);

  add_lane u_add (
    .clock (clock),
    .reset (reset),
    .a     (ADD_A[sel]),
    .b     (ADD_B[sel]),
    .y     (add_y)
  );

  // lane k of vector i reuses ADD entry (i+k) mod 8
  for (genvar k = 0; k < LN; k++) begin : g_lane
    logic [2:0] lsel;
    assign lsel = sel + 3'(k);
    assign vexp[k*LW +: LW] = ADD_Y[lsel];
    add_lane u_v (
      .clock (clock),
      .reset (reset),
      .a     (ADD_A[lsel]),
      .b     (ADD_B[lsel]),
      .y     (vadd_y[k*LW +: LW])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mac_y <= '0;
    else        mac_y <= MAC_A[sel] * MAC_B[sel] + MAC_C[sel];
  end

  always_comb begin
    exp_d = '0;
    unique case (1'b1)
      (state == RUN_ADD):  exp_d = {24'd0, ADD_Y[sel]};
      (state == RUN_VADD): exp_d = vexp;
      (state == RUN_MAC):  exp_d = {24'd0, MAC_Y[sel]};
      default:             exp_d = '0;
    endcase
  end

  assign flip = INJECT_FAULT && (ph_q == RUN_ADD) &&
                (idx_q == 3'd3);

  always_comb begin
    got = '0;
    unique case (1'b1)
      (ph_q == RUN_ADD):  got = {24'd0, add_y ^ {7'd0, flip}};
      (ph_q == RUN_VADD): got = vadd_y;
      (ph_q == RUN_MAC):  got = {24'd0, mac_y};
      default:            got = '0;
    endcase
  end

  assign mismatch = vld_q && (got != exp_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ph_q     <= IDLE;
      idx      <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      exp_q    <= '0;
      fail_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      vld_q <= issue;
      exp_q <= exp_d;
      ph_q  <= state;
      idx_q <= sel;
      if (mismatch) begin
        state    <= FAIL;
        idx      <= '0;
        fail_q   <= 1'b1;
        finish_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= RUN_ADD;
            idx   <= '0;
          end
          RUN_ADD, RUN_VADD, RUN_MAC: begin
            if (idx == LAST) begin
              idx <= '0;
              unique case (state)
                RUN_ADD:  state <= RUN_VADD;
                RUN_VADD: state <= RUN_MAC;
                default: begin
                  state    <= DONE;
                  finish_q <= 1'b1;
                end
              endcase
            end else begin
              idx <= idx + 4'd1;
            end
          end
          DONE:    finish_q <= 1'b1;
          default: state    <= FAIL;
        endcase
      end
    end
  end

  assign bus.fail   = fail_q;
  assign bus.finish = finish_q;

endmodule

// File: tb/tb_test_add_suite.sv
// Bench for test_add_suite: clean and fault-injected instances,
// edge-accurate status checks, datapath probes, random reset pulses.
module tb_test_add_suite;

  localparam int NV    = 8;
  localparam int E_FIN = 1 + 3 * (NV + 1);
  localparam int E_FLT = 1 + 3 + 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  test_add_suite_if u_if ();
  test_add_suite_if f_if ();

  test_add_suite #(.NUM_VEC(NV), .INJECT_FAULT(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.master)
  );

  test_add_suite #(.NUM_VEC(NV), .INJECT_FAULT(1'b1)) flt (
    .clock (clock),
    .reset (reset),
    .bus   (f_if.master)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  int ta [8] = '{0, 1, 127, 255, 200, 255, 15, 85};
  int tb [8] = '{0, 2, 1, 1, 100, 255, 240, 170};
  int ma [8] = '{0, 2, 16, 255, 10, 128, 7, 3};
  int mb [8] = '{0, 3, 16, 255, 10, 2, 9, 5};
  int mc [8] = '{0, 4, 1, 0, 56, 0, 200, 255};

  function automatic logic [7:0] m_add(int i);
    return 8'((ta[i] + tb[i]) % 256);
  endfunction

  function automatic logic [31:0] m_vadd(int i);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = m_add((i + k) % 8);
    return r;
  endfunction

  function automatic logic [7:0] m_mac(int i);
    return 8'((ma[i] * mb[i] + mc[i]) % 256);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (16) @(negedge clock);
    n_vec++;
    if (u_if.fail !== 1'b0 || u_if.finish !== 1'b0 ||
        f_if.fail !== 1'b0 || f_if.finish !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out got %b%b%b%b want 0000",
               u_if.fail, u_if.finish, f_if.fail, f_if.finish);
    end
    n_vec++;
    if (dut.idx !== 4'd0 || dut.add_y !== 8'd0 ||
        dut.mac_y !== 8'd0 || dut.vadd_y !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state idx=%0d add=%0d mac=%0d vadd=%h want 0",
               dut.idx, dut.add_y, dut.mac_y, dut.vadd_y);
    end
  endtask

  task automatic test_run();
    reset = 1'b1;
    for (int e = 1; e <= E_FIN + 8; e++) begin
      @(posedge clock);
      @(negedge clock);
      n_vec++;
      if (u_if.fail !== 1'b0 || u_if.finish !== (e >= E_FIN)) begin
        n_err++;
        $display("FAIL run edge %0d fail=%b finish=%b want 0/%b",
                 e, u_if.fail, u_if.finish, e >= E_FIN);
      end
      n_vec++;
      if (f_if.fail !== (e >= E_FLT) || f_if.finish !== 1'b0) begin
        n_err++;
        $display("FAIL inject edge %0d fail=%b finish=%b want %b/0",
                 e, f_if.fail, f_if.finish, e >= E_FLT);
      end
      if (e >= 2 && e <= NV + 1) begin
        n_vec++;
        if (dut.add_y !== m_add(e - 2)) begin
          n_err++;
          $display("FAIL add_probe vec %0d got %0d want %0d",
                   e - 2, dut.add_y, m_add(e - 2));
        end
      end
      if (e >= NV + 3 && e <= 2 * NV + 2) begin
        n_vec++;
        if (dut.vadd_y !== m_vadd(e - NV - 3)) begin
          n_err++;
          $display("FAIL vadd_probe vec %0d got %h want %h",
                   e - NV - 3, dut.vadd_y, m_vadd(e - NV - 3));
        end
      end
      if (e >= 2 * NV + 4 && e <= 3 * NV + 3) begin
        n_vec++;
        if (dut.mac_y !== m_mac(e - 2 * NV - 4)) begin
          n_err++;
          $display("FAIL mac_probe vec %0d got %0d want %0d",
                   e - 2 * NV - 4, dut.mac_y, m_mac(e - 2 * NV - 4));
        end
      end
    end
  endtask

  task automatic test_reset_mid_vadd();
    int hold;
    int k;
    int off;
    for (int r = 0; r < 4; r++) begin
      hold = int'($urandom_range(1, 4));
      k    = int'($urandom_range(NV + 2, 2 * NV + 2));
      off  = int'($urandom_range(1, 3));
      @(negedge clock);
      reset = 1'b0;
      repeat (hold) @(negedge clock);
      reset = 1'b1;
      repeat (k) @(posedge clock);
      @(negedge clock);
      n_vec++;
      if (f_if.fail !== 1'b1 || u_if.finish !== 1'b0) begin
        n_err++;
        $display("FAIL pre_pulse edge %0d inj_fail=%b finish=%b want 1/0",
                 k, f_if.fail, u_if.finish);
      end
      #(off);
      reset = 1'b0;
      #1;
      n_vec++;
      if (u_if.fail !== 1'b0 || u_if.finish !== 1'b0 ||
          f_if.fail !== 1'b0 || dut.idx !== 4'd0) begin
        n_err++;
        $display("FAIL async_clear fail=%b fin=%b inj=%b idx=%0d want 0",
                 u_if.fail, u_if.finish, f_if.fail, dut.idx);
      end
      repeat (hold) @(negedge clock);
      reset = 1'b1;
      for (int e = 1; e <= E_FIN + 2; e++) begin
        @(posedge clock);
        @(negedge clock);
        n_vec++;
        if (u_if.fail !== 1'b0 || u_if.finish !== (e >= E_FIN)) begin
          n_err++;
          $display("FAIL restart edge %0d fail=%b finish=%b want 0/%b",
                   e, u_if.fail, u_if.finish, e >= E_FIN);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_reset_mid_vadd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/test_add_suite.md
TEST_ADD_SUITE -- requirements
Module: test_add_suite

Interface
REQ-001 Parameter NUM_VEC, default 8: number of vectors per test phase (1..8); the table holds 8 entries.
REQ-002 Parameter INJECT_FAULT, default 0: when 1, the scalar-add result of vector 3 has bit 0 inverted before checking.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 fail  output  1  sticky; 1 once any check mismatches.
REQ-006 finish  output  1  sticky; 1 once all phases pass.

Function
REQ-007 The block SHALL be a self-checking harness with three datapaths: ADD (y=a+b), VADD (4 independent 8-bit lanes, y[k]=a[k]+b[k]), and MAC (y=a*b+c).
REQ-008 All results SHALL be truncated to 8 bits per lane (mod 256), with no carry between VADD lanes.
REQ-009 Each datapath SHALL register its result, giving 1-cycle latency from operand issue to the compare.
REQ-010 The FSM states SHALL be IDLE, RUN_ADD, RUN_VADD, RUN_MAC, DONE and FAIL.
REQ-011 IDLE SHALL last 1 cycle after reset release, then go to RUN_ADD.
REQ-012 Each RUN state SHALL last NUM_VEC+1 cycles: NUM_VEC issue cycles (index 0..NUM_VEC-1), then 1 drain cycle for the last compare.
REQ-013 The phases SHALL run in the order RUN_ADD, RUN_VADD, RUN_MAC, then DONE.
REQ-014 The ADD table (a,b,expected), indices 0-7, SHALL be: (0,0,0) (1,2,3) (127,1,128) (255,1,0) (200,100,44) (255,255,254) (15,240,255) (85,170,255).
REQ-015 VADD lane k of vector i SHALL use ADD entry (i+k) mod 8; the expected value is that entry's result per lane.
REQ-016 The MAC table (a,b,c,expected) SHALL be: (0,0,0,0) (2,3,4,10) (16,16,1,1) (255,255,0,1) (10,10,56,156) (128,2,0,0) (7,9,200,7) (3,5,255,14).
REQ-017 The expected value SHALL be delayed alongside the result; the compare is valid only in cycles following an issue cycle.
REQ-018 Any mismatch SHALL move the FSM to FAIL on the same edge that registers fail=1.
REQ-019 FAIL SHALL be terminal, with finish held at 0.
REQ-020 DONE SHALL be terminal, with finish=1 and fail=0.
REQ-021 fail and finish SHALL never both be 1.
REQ-022 With NUM_VEC=8, finish SHALL rise on the 28th rising edge after reset deasserts.

Reset
REQ-023 While reset=0, the FSM SHALL be in IDLE, with the index, pipeline registers, fail and finish all 0.
REQ-024 Reset asserted mid-phase SHALL abort immediately, and the run SHALL restart from RUN_ADD index 0 after release.

Structure
REQ-025 A shared package SHALL hold the state enum, the lane width (8), the lane count (4) and both vector tables as constant arrays.
REQ-026 One sub-module, add_lane (8-bit registered adder), SHALL be instantiated once for ADD and four times for VADD.
REQ-027 MAC SHALL be implemented inline.

Verification
REQ-028 Default parameters, reset held low 16 cycles then released -> fail=0 throughout; finish=1 exactly at edge 28 after release, and it stays 1.
REQ-029 INJECT_FAULT=1 -> fail=1 on the edge that compares ADD vector 3 (edge 6 after release); finish stays 0.
REQ-030 Internal probe of the ADD result -> vector 3 (255+1) gives 0 and vector 5 gives 254 (wrap-around).
REQ-031 Internal probe of the VADD result -> vector 7 lane 1 (ADD entry 0: 0+0) gives 0, and lane 0 gives 255 with no carry into lane 1.
REQ-032 Internal probe of the MAC result -> vector 3 (255*255+0) gives 1 and vector 6 (7*9+200) gives 7.
REQ-033 Reset pulsed low during RUN_VADD -> outputs go to 0 asynchronously; after release, finish rises 28 edges later.
